ultrasonic_scheduler: RTL

ULTRASONIC_SCHEDULER -- requirements
Module: ultrasonic_scheduler

---
 rtl/follower_pkg.sv | 35 +++
 rtl/us_tick_gen.sv | 29 ++
 rtl/ultrasonic_scheduler.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/follower_pkg.sv
// Shared definitions for the three-channel ultrasonic ranging scheduler:
// controller states, channel count and default timing.
package follower_pkg;

    localparam int NUM_CH           = 3;
    localparam int DEF_TICKS_PER_US = 100;
    localparam int DEF_TRIG_US      = 10;
    localparam int DEF_TIMEOUT_US   = 30000;
    localparam int DEF_SLOT_US      = 60000;

    localparam logic [15:0] NO_ECHO = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_GAP
    } state_t;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] ch);
        logic [NUM_CH-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch == 2'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    // Round-robin successor; the last channel wraps back to channel 0.
    function automatic logic [1:0] ch_next(input logic [1:0] ch);
        return (ch == 2'(NUM_CH - 1)) ? 2'd0 : ch + 2'd1;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond strobe: one-cycle tick every TICKS_PER_US clocks, held at phase 0 while clear is high.
module us_tick_gen #(
    parameter int TICKS_PER_US = 100
) (
    input  logic PCLK,
    input  logic RESET,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_US - 1);

    logic [CW-1:0] cnt;

    // tick is not gated by clear: the controller uses it to decide when to clear.
    assign tick = (cnt == LAST);

    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ultrasonic_scheduler.sv
// Round-robin scheduler for three ultrasonic rangers: fires one trigger per slot,
// times the echo pulse of the selected channel and keeps the latest width per channel.
module ultrasonic_scheduler
    import follower_pkg::*;
#(
    parameter int TICKS_PER_US = DEF_TICKS_PER_US,
    parameter int TRIG_US      = DEF_TRIG_US,
    parameter int TIMEOUT_US   = DEF_TIMEOUT_US,
    parameter int SLOT_US      = DEF_SLOT_US
) (
    input  logic                   PCLK,
    input  logic                   RESET,
    input  logic                   enable,
    input  logic [NUM_CH-1:0]      echo,
    output logic [NUM_CH-1:0]      trig,
    output logic                   meas_valid,
    output logic [1:0]             meas_ch,
    output logic [15:0]            meas_us,
    output logic [16*NUM_CH-1:0]   dist_us
);

    // Microsecond counts measured from the trigger rise (slot_us == 0 during the first microsecond).
    localparam logic [31:0] TRIG_LAST    = 32'(TRIG_US - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TRIG_US + TIMEOUT_US - 1);
    localparam logic [31:0] SLOT_LAST    = 32'(SLOT_US - 1);

    state_t state, state_next;

    logic [NUM_CH-1:0] sync1, sync2;
    logic              echo_sel, echo_prev, echo_rise, echo_fall;
    logic              tick, tick_clear, enter_trig, timeout;
    logic [31:0]       slot_us;
    logic [15:0]       width_cnt;
    logic [1:0]        ch_nxt;
    logic              latch_en;
    logic [15:0]       latch_val;

    us_tick_gen #(.TICKS_PER_US(TICKS_PER_US)) u_tick (
        .PCLK  (PCLK),
        .RESET (RESET),
        .clear (tick_clear),
        .tick  (tick)
    );

    always_comb begin
        echo_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (meas_ch == 2'(i)) echo_sel = sync2[i];
        end
    end

    // echo_prev tracks the selected line continuously, so an echo already high
    // when WAIT_RISE is entered never looks like a rising edge.
    assign echo_rise = echo_sel & ~echo_prev;
    assign echo_fall = ~echo_sel & echo_prev;
    assign timeout   = tick && (slot_us == TIMEOUT_LAST);

    always_comb begin
        state_next = state;
        ch_nxt     = meas_ch;
        latch_en   = 1'b0;
        latch_val  = NO_ECHO;
        case (state)
            ST_IDLE: begin
                if (enable) state_next = ST_TRIG;
            end
            ST_TRIG: begin
                if (tick && (slot_us == TRIG_LAST)) state_next = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (timeout) begin
                    latch_en   = 1'b1;
                    state_next = ST_GAP;
                end else if (echo_rise) begin
                    state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // A falling edge coinciding with the timeout still reports the width.
                if (echo_fall) begin
                    latch_en   = 1'b1;
                    latch_val  = width_cnt;
                    state_next = ST_GAP;
                end else if (timeout) begin
                    latch_en   = 1'b1;
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tick && (slot_us == SLOT_LAST)) begin
                    ch_nxt     = ch_next(meas_ch);
                    state_next = enable ? ST_TRIG : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign enter_trig = (state_next == ST_TRIG) && (state != ST_TRIG);
    assign tick_clear = (state == ST_IDLE) || enter_trig;

    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            sync1     <= '0;
            sync2     <= '0;
            echo_prev <= 1'b0;
            slot_us   <= '0;
            width_cnt <= '0;
        end else begin
            state     <= state_next;
            sync1     <= echo;
            sync2     <= sync1;
            echo_prev <= echo_sel;
            if (enter_trig) begin
                slot_us <= '0;
            end else if (tick) begin
                slot_us <= slot_us + 32'd1;
            end
            if ((state == ST_WAIT_RISE) && (state_next == ST_MEASURE)) begin
                width_cnt <= '0;
            end else if ((state == ST_MEASURE) && tick && (width_cnt != NO_ECHO)) begin
                width_cnt <= width_cnt + 16'd1;
            end
        end
    end

    // Outputs are registered from the next-state decode; the async reset drops trig immediately.
    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            trig       <= '0;
            meas_valid <= 1'b0;
            meas_ch    <= 2'd0;
            meas_us    <= NO_ECHO;
            dist_us    <= {NUM_CH{NO_ECHO}};
        end else begin
            trig       <= (state_next == ST_TRIG) ? ch_onehot(ch_nxt) : '0;
            meas_valid <= latch_en;
            meas_ch    <= ch_nxt;
            if (latch_en) begin
                meas_us <= latch_val;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (meas_ch == 2'(i)) dist_us[16*i +: 16] <= latch_val;
                end
            end
        end
    end

endmodule
